// File: rtl/rv_regfile_pkg.sv
// Shared constants and types for the integer register file.
//
// Contents:
//   REG_COUNT   - number of architectural registers (x00..x31)
//   REG_ADDR_W  - width of a register index
//   ZERO_REG    - index of the hardwired-zero register
//   reg_addr_t  - register index type
//   is_zero_reg - true when an index names the hardwired-zero register
package rv_regfile_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == reg_addr_t'(ZERO_REG);
  endfunction

endpackage

// File: rtl/decoder_5_to_32.sv
// 5-to-32 one-hot decoder with enable.
//
// Ports:
//   en_i     - when low, every output bit is low
//   addr_i   - index to decode
//   onehot_o - bit addr_i set when en_i is high, all zero otherwise
module decoder_5_to_32
  import rv_regfile_pkg::*;
(
  input  logic                 en_i,
  input  reg_addr_t            addr_i,
  output logic [REG_COUNT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_32to1.sv
// Generic 32:1 multiplexer, Width bits per input.
//
// Ports:
//   data_i - REG_COUNT packed input words, word k selected by sel_i == k
//   sel_i  - select index
//   data_o - selected word
module mux_32to1
  import rv_regfile_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [REG_COUNT-1:0][Width-1:0] data_i,
  input  reg_addr_t                       sel_i,
  output logic [Width-1:0]                data_o
);

  assign data_o = data_i[sel_i];

endmodule

// File: rtl/register_file.sv
// 32-entry, two-read/one-write register file with hardwired-zero x00.
//
// Parameters:
//   N       - width of every register and data port
//   FORWARD - 1: a read of the register being written returns wr_data in the same
//             cycle; 0: the read returns the old value until the next cycle
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset, clears every register
//   wr_ena   - write enable
//   wr_addr  - write register index
//   wr_data  - write data
//   rd_addr0 - read port 0 index,   rd_data0 - read port 0 data (combinational)
//   rd_addr1 - read port 1 index,   rd_data1 - read port 1 data (combinational)
module register_file
  import rv_regfile_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter bit          FORWARD = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  reg_addr_t    wr_addr,
  input  logic [N-1:0] wr_data,
  input  reg_addr_t    rd_addr0,
  output logic [N-1:0] rd_data0,
  input  reg_addr_t    rd_addr1,
  output logic [N-1:0] rd_data1
);

  // Per-register write enables.
  logic [REG_COUNT-1:0] reg_we;

  decoder_5_to_32 u_wr_dec (
    .en_i     (wr_ena),
    .addr_i   (wr_addr),
    .onehot_o (reg_we)
  );

  // x00 has no storage, so its enable is deliberately dropped.
  logic unused_reg_we0;
  assign unused_reg_we0 = reg_we[ZERO_REG];

  // Storage for x01..x31 only.
  logic [N-1:0] regs_q [REG_COUNT-1:1];

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_regs
    always_ff @(posedge clk) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (reg_we[i]) begin
        regs_q[i] <= wr_data;
      end
    end
  end

  // Flatten storage into the mux input bus; slot 0 is the constant zero register.
  logic [REG_COUNT-1:0][N-1:0] rd_bus;

  always_comb begin
    rd_bus           = '0;
    rd_bus[ZERO_REG] = '0;
    for (int unsigned k = 1; k < REG_COUNT; k++) begin
      rd_bus[k] = regs_q[k];
    end
  end

  logic [N-1:0] rd_raw0;
  logic [N-1:0] rd_raw1;

  mux_32to1 #(
    .Width (N)
  ) u_rd_mux0 (
    .data_i (rd_bus),
    .sel_i  (rd_addr0),
    .data_o (rd_raw0)
  );

  mux_32to1 #(
    .Width (N)
  ) u_rd_mux1 (
    .data_i (rd_bus),
    .sel_i  (rd_addr1),
    .data_o (rd_raw1)
  );

  // A write is only bypassable when it will actually land: not during reset and
  // never to x00.
  logic wr_live;
  assign wr_live = wr_ena && !rst && !is_zero_reg(wr_addr);

  logic fwd0;
  logic fwd1;
  assign fwd0 = FORWARD && wr_live && (wr_addr == rd_addr0);
  assign fwd1 = FORWARD && wr_live && (wr_addr == rd_addr1);

  // Zero override is applied last so x00 reads zero regardless of any bypass.
  always_comb begin
    rd_data0 = rd_raw0;
    if (fwd0) begin
      rd_data0 = wr_data;
    end
    if (is_zero_reg(rd_addr0)) begin
      rd_data0 = '0;
    end
  end

  always_comb begin
    rd_data1 = rd_raw1;
    if (fwd1) begin
      rd_data1 = wr_data;
    end
    if (is_zero_reg(rd_addr1)) begin
      rd_data1 = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd0_f, rd1_f, rd0_n, rd1_n;

  always #5 clk = ~clk;

  register_file #(.N(32), .FORWARD(1'b1)) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd0_f),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd1_f)
  );

  register_file #(.N(32), .FORWARD(1'b0)) u_nofwd (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd0_n),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd1_n)
  );

  typedef struct packed {
    logic [1:0]  sel;   // 0: fwd p0, 1: fwd p1, 2: nofwd p0, 3: nofwd p1
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  logic [31:0] model [32];
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit fwd, input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (fwd && wr_ena && !rst && (wr_addr == addr)) return wr_data;
    return model[addr];
  endfunction

  // Compare everything queued for this cycle at the falling edge, then advance
  // the reference model across the rising edge.
  task automatic step();
    exp_t  e;
    string t;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      case (e.sel)
        2'd0: check_eq(t, rd0_f, e.val);
        2'd1: check_eq(t, rd1_f, e.val);
        2'd2: check_eq(t, rd0_n, e.val);
        default: check_eq(t, rd1_n, e.val);
      endcase
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wr_ena && wr_addr != 5'd0) begin
      model[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1, input string tag);
    rst      = r;
    wr_ena   = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr0 = a0;
    rd_addr1 = a1;
    exp_q.push_back('{sel: 2'd0, val: exp_rd(1'b1, a0)});
    tag_q.push_back($sformatf("%s/f0[%0d]", tag, a0));
    exp_q.push_back('{sel: 2'd1, val: exp_rd(1'b1, a1)});
    tag_q.push_back($sformatf("%s/f1[%0d]", tag, a1));
    exp_q.push_back('{sel: 2'd2, val: exp_rd(1'b0, a0)});
    tag_q.push_back($sformatf("%s/n0[%0d]", tag, a0));
    exp_q.push_back('{sel: 2'd3, val: exp_rd(1'b0, a1)});
    tag_q.push_back($sformatf("%s/n1[%0d]", tag, a1));
    step();
  endtask

  initial begin
    rst      = 1'b1;
    wr_ena   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr0 = '0;
    rd_addr1 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(posedge clk);
    #1;

    // Reset held: stored contents are zero.
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31, "rst_hold");

    // All 32 indices on both ports read zero after reset.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "post_rst");
    end

    // Write x05, then read it on both ports.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, "wr_x05");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd_x05");

    // Writes to x00 are discarded, even in the write cycle.
    cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, "wr_x00");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd_x00");

    // Bypass to x31: new value on FORWARD=1, old value on FORWARD=0.
    cycle(1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5, "wr_x31");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31, "rd_x31");

    // Reset wins over a simultaneous write; no bypass while in reset.
    cycle(1'b0, 1'b1, 5'd10, 32'h00001111, 5'd10, 5'd10, "wr_x10");
    cycle(1'b1, 1'b1, 5'd10, 32'hFFFFFFFF, 5'd10, 5'd5, "rst_wr_x10");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd5, "after_rst");
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0, "after_rst2");

    // Fill x01..x31 with index*0x01010101, reading the target back in the write cycle.
    for (int i = 1; i < 32; i++) begin
      cycle(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'($urandom_range(0, 31)),
            "fill");
    end

    // Random dual-port reads; write bus toggles with enable low and must not bypass.
    for (int c = 0; c < 1000; c++) begin
      cycle(1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
